uart_tx_unit: RTL and testbench

UART_TX_UNIT -- requirements
Module: uart_tx_unit

---
 rtl/uart_tx_unit.sv | 135 +++++++++++++
 tb/tb_uart_tx_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_unit.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional parity, stop bit(s).
// Timing comes from a 16x oversampling s_tick strobe; the serial line output is registered.
module uart_tx_unit #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned PARITY  = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic [DBIT-1:0] din,
  input  logic            wr_valid,
  output logic            wr_ready,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // Any PARITY value other than even (1) or odd (2) means no parity bit.
  localparam bit         HasParity = (PARITY == 1) || (PARITY == 2);
  localparam logic [2:0] LastBit   = 3'(DBIT - 1);
  localparam logic [4:0] LastStop  = 5'(SB_TICK - 1);
  localparam logic [4:0] LastTick  = 5'd15;

  state_e          state_q, state_d;
  logic [4:0]      s_q, s_d;
  logic [2:0]      n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            par_q, par_d;
  logic            tx_q;
  logic            line;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      par_q   <= par_d;
      tx_q    <= line;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    par_d   = par_q;
    unique case (state_q)
      StIdle: begin
        if (wr_valid) begin
          state_d = StStart;
          s_d     = '0;
          b_d     = din;
          par_d   = (PARITY == 2) ? ~^din : ^din;
        end
      end
      StStart: begin
        if (s_tick) begin
          if (s_q == LastTick) begin
            state_d = StData;
            s_d     = '0;
            n_d     = '0;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (s_q == LastTick) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == LastBit) begin
              state_d = HasParity ? StParity : StStop;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      StParity: begin
        if (s_tick) begin
          if (s_q == LastTick) begin
            state_d = StStop;
            s_d     = '0;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      StStop: begin
        if (s_tick) begin
          if (s_q == LastStop) begin
            state_d = StIdle;
            s_d     = '0;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ready     = (state_q == StIdle);
    tx_busy      = (state_q != StIdle);
    tx_done_tick = (state_q == StStop) && s_tick && (s_q == LastStop);
    line         = 1'b1;
    unique case (state_q)
      StIdle:   line = 1'b1;
      StStart:  line = 1'b0;
      StData:   line = b_q[0];
      StParity: line = par_q;
      StStop:   line = 1'b1;
      default:  line = 1'b1;
    endcase
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit: three instances cover no parity, even parity and odd parity.
// Inputs change on the falling edge; outputs are sampled 1 ns before the rising edge.
module tb_uart_tx_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       wr_valid;
  logic [7:0] din;
  logic [1:0] sel;
  int         tick_cnt;

  logic [2:0] wv, rdy_v, tx_v, busy_v, done_v;
  logic       tx_m, rdy_m, busy_m, done_m;

  int          tests = 0;
  int          fails = 0;
  int          cap_ticks, cap_done, cap_busy_bad;
  logic [15:0] cap_bits;
  logic        cap_rdy0, cap_tx0, cap_tx1, cap_tx2;

  always #5 clk = ~clk;

  assign wv[0]  = wr_valid && (sel == 2'd0);
  assign wv[1]  = wr_valid && (sel == 2'd1);
  assign wv[2]  = wr_valid && (sel == 2'd2);
  assign tx_m   = tx_v[sel];
  assign rdy_m  = rdy_v[sel];
  assign busy_m = busy_v[sel];
  assign done_m = done_v[sel];

  uart_tx_unit #(.DBIT(8), .SB_TICK(16), .PARITY(0)) dut_none (
    .clk(clk), .reset(reset), .s_tick(s_tick), .din(din), .wr_valid(wv[0]),
    .wr_ready(rdy_v[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done_tick(done_v[0])
  );
  uart_tx_unit #(.DBIT(8), .SB_TICK(16), .PARITY(1)) dut_even (
    .clk(clk), .reset(reset), .s_tick(s_tick), .din(din), .wr_valid(wv[1]),
    .wr_ready(rdy_v[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done_tick(done_v[1])
  );
  uart_tx_unit #(.DBIT(8), .SB_TICK(16), .PARITY(2)) dut_odd (
    .clk(clk), .reset(reset), .s_tick(s_tick), .din(din), .wr_valid(wv[2]),
    .wr_ready(rdy_v[2]), .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done_tick(done_v[2])
  );

  // One-clk s_tick every 10 clks.
  initial begin
    s_tick   = 1'b0;
    tick_cnt = 0;
    forever begin
      @(negedge clk);
      tick_cnt = (tick_cnt == 9) ? 0 : tick_cnt + 1;
      s_tick   = (tick_cnt == 9);
    end
  end

  // Accepts one word, then follows the frame until tx_done_tick (or a cycle budget).
  // The line is sampled on the 8th tick of each 16-tick bit into cap_bits.
  task automatic capture(input logic [7:0] data, input logic [7:0] din_after,
                         input logic hold_after, input int pulse_tick);
    int ticks = 0;
    bit pulsed = 0;
    bit done_seen = 0;
    cap_ticks = -1; cap_done = 0; cap_busy_bad = 0; cap_bits = '0;
    @(negedge clk);
    reset = 1'b0; wr_valid = 1'b1; din = data;
    #4;
    cap_rdy0 = rdy_m; cap_tx0 = tx_m;
    for (int c = 1; c < 3000 && !done_seen; c++) begin
      @(negedge clk);
      wr_valid = hold_after; din = din_after;
      if (!pulsed && pulse_tick >= 0 && ticks == pulse_tick) begin
        wr_valid = 1'b1; din = 8'hFF; pulsed = 1;
      end
      #4;
      if (c == 1) cap_tx1 = tx_m;
      if (c == 2) cap_tx2 = tx_m;
      if (s_tick) begin
        if (ticks % 16 == 7 && ticks < 256) cap_bits[4'(ticks / 16)] = tx_m;
        ticks++;
      end
      if (done_m) begin
        cap_done++; cap_ticks = ticks; done_seen = 1;
      end else if (rdy_m || !busy_m) begin
        cap_busy_bad++;
      end
    end
  endtask

  task automatic test_reset();
    int busy_seen = 0;
    sel = 2'd0; reset = 1'b1; wr_valid = 1'b1; din = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #4;
      tests++; if (tx_m !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b want 1", tx_m); end
      tests++; if (rdy_m !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", rdy_m); end
      tests++; if (busy_m !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy_m); end
      tests++; if (done_m !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done_m); end
    end
    @(negedge clk); reset = 1'b0; wr_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #4;
      if (busy_m !== 1'b0 || tx_m !== 1'b1) busy_seen++;
    end
    tests++;
    if (busy_seen != 0) begin fails++; $display("FAIL reset_no_frame: got %0d busy clks want 0", busy_seen); end
  endtask

  task automatic test_basic_frame();
    int extra = 0;
    sel = 2'd0;
    capture(8'hA5, 8'hA5, 1'b0, -1);
    wr_valid = 1'b0;
    tests++; if (cap_rdy0 !== 1'b1) begin fails++; $display("FAIL basic_ready: got %b want 1", cap_rdy0); end
    tests++; if (cap_tx1 !== 1'b1) begin fails++; $display("FAIL basic_tx_c1: got %b want 1", cap_tx1); end
    tests++; if (cap_tx2 !== 1'b0) begin fails++; $display("FAIL basic_tx_fall: got %b want 0", cap_tx2); end
    tests++;
    if (cap_bits[9:0] !== {1'b1, 8'hA5, 1'b0}) begin
      fails++; $display("FAIL basic_bits: got %b want %b", cap_bits[9:0], {1'b1, 8'hA5, 1'b0});
    end
    tests++; if (cap_done != 1) begin fails++; $display("FAIL basic_done: got %0d want 1", cap_done); end
    tests++; if (cap_ticks != 160) begin fails++; $display("FAIL basic_len: got %0d want 160", cap_ticks); end
    tests++; if (cap_busy_bad != 0) begin fails++; $display("FAIL basic_busy: got %0d want 0", cap_busy_bad); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #4;
      if (done_m !== 1'b0 || busy_m !== 1'b0 || tx_m !== 1'b1) extra++;
    end
    tests++; if (extra != 0) begin fails++; $display("FAIL basic_after: got %0d bad clks want 0", extra); end
  endtask

  task automatic test_parity();
    sel = 2'd1;
    capture(8'h07, 8'h07, 1'b0, -1);
    wr_valid = 1'b0;
    tests++;
    if (cap_bits[10:0] !== {1'b1, 1'b1, 8'h07, 1'b0}) begin
      fails++; $display("FAIL even_bits: got %b want %b", cap_bits[10:0], {1'b1, 1'b1, 8'h07, 1'b0});
    end
    tests++; if (cap_ticks != 176) begin fails++; $display("FAIL even_len: got %0d want 176", cap_ticks); end
    sel = 2'd2;
    capture(8'h07, 8'h07, 1'b0, -1);
    wr_valid = 1'b0;
    tests++;
    if (cap_bits[10:0] !== {1'b1, 1'b0, 8'h07, 1'b0}) begin
      fails++; $display("FAIL odd_bits: got %b want %b", cap_bits[10:0], {1'b1, 1'b0, 8'h07, 1'b0});
    end
    tests++; if (cap_ticks != 176) begin fails++; $display("FAIL odd_len: got %0d want 176", cap_ticks); end
    sel = 2'd0;
  endtask

  task automatic test_busy_reject();
    int extra = 0;
    sel = 2'd0;
    capture(8'hA5, 8'hA5, 1'b0, 40);
    wr_valid = 1'b0;
    tests++;
    if (cap_bits[9:0] !== {1'b1, 8'hA5, 1'b0}) begin
      fails++; $display("FAIL busy_bits: got %b want %b", cap_bits[9:0], {1'b1, 8'hA5, 1'b0});
    end
    tests++; if (cap_ticks != 160) begin fails++; $display("FAIL busy_len: got %0d want 160", cap_ticks); end
    tests++; if (cap_busy_bad != 0) begin fails++; $display("FAIL busy_ready: got %0d want 0", cap_busy_bad); end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #4;
      if (busy_m !== 1'b0) extra++;
    end
    tests++; if (extra != 0) begin fails++; $display("FAIL busy_second: got %0d busy clks want 0", extra); end
  endtask

  task automatic test_midframe_reset();
    int ticks = 0;
    int pre_done = 0;
    sel = 2'd0;
    @(negedge clk); wr_valid = 1'b1; din = 8'hC3;
    for (int c = 0; c < 3000 && ticks < 72; c++) begin
      @(negedge clk); wr_valid = 1'b0;
      #4;
      if (s_tick) ticks++;
      if (done_m) pre_done++;
    end
    @(negedge clk); reset = 1'b1;
    #4;
    if (done_m) pre_done++;
    capture(8'h3C, 8'h3C, 1'b0, -1);
    wr_valid = 1'b0;
    tests++; if (pre_done != 0) begin fails++; $display("FAIL rst_done: got %0d want 0", pre_done); end
    tests++; if (cap_tx0 !== 1'b1) begin fails++; $display("FAIL rst_tx: got %b want 1", cap_tx0); end
    tests++; if (cap_rdy0 !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", cap_rdy0); end
    tests++;
    if (cap_bits[9:0] !== {1'b1, 8'h3C, 1'b0}) begin
      fails++; $display("FAIL rst_bits: got %b want %b", cap_bits[9:0], {1'b1, 8'h3C, 1'b0});
    end
    tests++; if (cap_ticks != 160) begin fails++; $display("FAIL rst_len: got %0d want 160", cap_ticks); end
  endtask

  task automatic test_back_to_back();
    sel = 2'd0;
    capture(8'h55, 8'hAA, 1'b1, -1);
    tests++;
    if (cap_bits[9:0] !== {1'b1, 8'h55, 1'b0}) begin
      fails++; $display("FAIL b2b_bits1: got %b want %b", cap_bits[9:0], {1'b1, 8'h55, 1'b0});
    end
    tests++; if (cap_done != 1) begin fails++; $display("FAIL b2b_done1: got %0d want 1", cap_done); end
    capture(8'hAA, 8'hAA, 1'b0, -1);
    wr_valid = 1'b0;
    tests++; if (cap_rdy0 !== 1'b1) begin fails++; $display("FAIL b2b_ready: got %b want 1", cap_rdy0); end
    tests++; if (cap_tx1 !== 1'b1) begin fails++; $display("FAIL b2b_gap: got %b want 1", cap_tx1); end
    tests++; if (cap_tx2 !== 1'b0) begin fails++; $display("FAIL b2b_start: got %b want 0", cap_tx2); end
    tests++;
    if (cap_bits[9:0] !== {1'b1, 8'hAA, 1'b0}) begin
      fails++; $display("FAIL b2b_bits2: got %b want %b", cap_bits[9:0], {1'b1, 8'hAA, 1'b0});
    end
    tests++; if (cap_ticks != 160) begin fails++; $display("FAIL b2b_len: got %0d want 160", cap_ticks); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity();
    test_busy_reject();
    test_midframe_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
